// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 5;

endpackage

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle over 32 CALC cycles, then a FIX cycle applies
// sign correction and writes HI/LO. Signed ops work on magnitudes.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     count;
  op_t                  op_q;
  logic                 neg_q;     // negate product / quotient
  logic                 neg_r;     // negate remainder (dividend was negative)
  logic [WIDTH-1:0]     operand_b; // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]   acc;       // {upper, lower} shift register pair

  logic                 is_div;
  logic                 is_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH+1:0]     add_x;
  logic [WIDTH+1:0]     add_y;
  logic [WIDTH+1:0]     add_sum;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  assign busy = (state != S_IDLE);

  // Operand sign decode at launch; unsigned ops never negate.
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & rs_data[WIDTH-1];
  assign b_neg     = is_signed & rt_data[WIDTH-1];
  assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Shared adder/subtractor: multiply adds the multiplicand to the upper half,
  // divide subtracts the divisor from the left-shifted partial remainder
  // (which needs WIDTH+1 bits, hence the extra bit taken from acc).
  always_comb begin
    add_x   = is_div ? {1'b0, acc[2*WIDTH-1:WIDTH-1]} : {2'b00, acc[2*WIDTH-1:WIDTH]};
    add_y   = is_div ? ~{2'b00, operand_b} : {2'b00, operand_b};
    add_sum = add_x + add_y + {{(WIDTH+1){1'b0}}, is_div};
  end

  assign prod_fix = neg_q ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic: launch, iterate until the counter expires, then fix up.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CALC;
      S_CALC:  if (count == '0) next_state = S_FIX;
      S_FIX:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture at launch and one shift/add step per CALC cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count     <= '0;
      op_q      <= OP_MULT;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      operand_b <= '0;
      acc       <= '0;
    end else if (state == S_IDLE && start) begin
      count     <= CNT_W'(ITER_COUNT - 1);
      op_q      <= op_t'(op);
      neg_q     <= a_neg ^ b_neg;
      neg_r     <= a_neg;
      operand_b <= b_neg ? (~rt_data + 1'b1) : rt_data;
      acc       <= {{WIDTH{1'b0}}, (a_neg ? (~rs_data + 1'b1) : rs_data)};
    end else if (state == S_CALC) begin
      count <= count - 1'b1;
      if (is_div) begin
        // Restoring step: keep the difference only when it did not borrow.
        if (!add_sum[WIDTH+1]) acc <= {add_sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else                   acc <= {acc[2*WIDTH-2:0], 1'b0};
      end else begin
        // Shift-add, LSB first: the multiplier drains out of the lower half.
        if (acc[0]) acc <= {add_sum[WIDTH:0], acc[WIDTH-1:1]};
        else        acc <= {1'b0, acc[2*WIDTH-1:1]};
      end
    end
  end

  // HI/LO: written on FIX, or by moves in IDLE when no operation is launched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      if (is_div) begin
        hi <= rem_fix;
        lo <= quo_fix;
      end else begin
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
      end
    end else if (state == S_IDLE && !start) begin
      if (mthi) hi <= rs_data;
      if (mtlo) lo <= rs_data;
    end
  end

  // Completion pulse in the cycle after the FIX write.
  always_ff @(posedge clk) begin
    if (!rst_n) done <= 1'b0;
    else        done <= (state == S_FIX);
  end

endmodule
